seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits directly downstream of the binary-to-BCD converter. It captures the four BCD digits (thousands, hundreds, tens, ones) on a load strobe and cycles through the digits at a programmable refresh rate, with a guard interval between digits to prevent ghosting. It also pulses a frame marker once per full scan.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= GUARD+1.
- GUARD, 2: cycles at the start of each slot with all anodes off; must be >= 0.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- load  input  1  capture digit inputs and dp_en at this rising edge.
- thousands  input  4  digit 3.
- hundreds  input  4  digit 2.
- tens  input  4  digit 1.
- ones  input  4  digit 0.
- dp_en  input  4  per-digit decimal point enable; bit k belongs to digit k.
- anode  output  4  active-low digit select; bit k drives digit k.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- frame_done  output  1  one-cycle pulse per completed 4-digit scan.

## Operation
- Shadow registers hold the 4 digits and dp_en.
  - Loaded on every clk edge where load=1; load held high recaptures every cycle.
  - Reset value is 0.
- The slot counter `cnt` counts 0..REFRESH_DIV-1.
  - Width is $clog2(REFRESH_DIV), minimum 1 bit.
  - At terminal count, `cnt` wraps to 0 and the digit index `idx` advances.
- `idx` sequence is 0→1→2→3→0, i.e. ones first, thousands last.
- frame_done is registered. It is 1 for exactly the cycle after the edge on which `idx` wraps 3→0.
- Output logic, evaluated from the current `cnt`/`idx`/shadow and registered:
  - If cnt < GUARD, or digit idx is blanked: anode=4'b1111, seg=7'h7F, dp=1.
  - Otherwise: anode = ~(4'b0001 << idx), seg = decode(shadow[idx]), dp = ~dp_en_shadow[idx].
- Decode covers all 16 codes; values 10–15 display hex A,b,C,d,E,F for debug.
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10
  - A:08 b:03 C:46 d:21 E:06 F:0E
- Non-blanking slots always drive their digit.

## Timing
- Reset values (applied asynchronously while rst_n=0): anode=4'b1111, seg=7'h7F, dp=1, frame_done=0, cnt=0, idx=0, shadows=0.
- First clock after rst_n deasserts: the guard phase of slot 0 begins.
- Output latency: outputs reflect cnt/idx/shadow one cycle later.
  - A load at edge N changes seg/dp at edge N+1 if the slot is active (mid-slot updates allowed).
- Slot length is REFRESH_DIV cycles: GUARD blank cycles, then REFRESH_DIV-GUARD active cycles. Frame = 4·REFRESH_DIV cycles.
- GUARD=0 gives no blank gap; anodes switch directly between digits.
- Reset asserted mid-frame:
  - Outputs blank immediately, with no clock needed.
  - Scan restarts at idx 0, cnt 0.
  - Shadows are cleared; the display shows 0000 until the next load.

## Configuration
- SEVEN_SEG_LZB_EN defined: leading-zero blanking is enabled.
  - Thousands is blanked if it is 0.
  - Hundreds is blanked if thousands and hundreds are both 0.
  - Tens is blanked if thousands, hundreds and tens are all 0.
  - Ones is never blanked.
  - A blanked slot keeps its timing, with all anodes high and dp off.
- SEVEN_SEG_LZB_EN undefined: no digit is ever blanked by value; leading zeros show as 7'h40.

## Structure
- Package seven_seg_pkg holds:
  - NUM_DIGITS=4
  - SEG_BLANK=7'h7F
  - ANODE_OFF=4'b1111
  - the 16-entry segment constant table
- Sub-module seg7_decode: combinational 4-bit code to active-low 7-bit pattern, using the package table; instantiated once on the muxed digit.

## Test plan
All scenarios use REFRESH_DIV=8, GUARD=2.
- Reset: hold rst_n=0 → anode=1111, seg=7F, dp=1, frame_done=0. Assert rst_n asynchronously between edges → outputs blank immediately.
- Load 1,2,3,4 (thousands→ones), dp_en=0 → repeating slots:
  - anode 1110/seg 19
  - anode 1101/seg 30
  - anode 1011/seg 24
  - anode 0111/seg 79
  - Each slot: 2 blank cycles, then 6 active cycles. frame_done pulses every 32 cycles.
- Load F,b,C,0 with dp_en=4'b0100 → seg 40, 46, 03, 0E for ones→thousands; dp=0 only while anode=1011.
- Load 0,0,4,2:
  - With SEVEN_SEG_LZB_EN: the hundreds and thousands slots stay anode=1111.
  - Without it: those slots show seg 40.
- Load 9999, then load 0001 during the third active cycle of the ones slot → seg changes 10→79 on the next cycle and the slot keeps its remaining timing.
- Reset pulse in the middle of the tens slot → after release the scan restarts in slot 0 showing 40 (all-zero shadows); frame_done does not fire until 32 cycles later.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and active-low segment table {g,f,e,d,c,b,a} for the scanner
package seven_seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  // Entry k is the pattern for code k; codes 10-15 show hex A,b,C,d,E,F for debug
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit code to active-low seven-segment pattern
module seg7_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_TABLE[i_code];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 4-digit multiplexed common-anode driver; define SEVEN_SEG_LZB_EN for leading-zero blanking
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] dp_en,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]                r_cnt;
  logic [1:0]                   r_idx;
  logic [NUM_DIGITS-1:0][3:0]   r_dig;
  logic [NUM_DIGITS-1:0]        r_dp_en;
  logic [3:0]                   r_anode;
  logic [6:0]                   r_seg;
  logic                         r_dp;
  logic                         r_frame_done;
  logic [3:0]                   w_code;
  logic [6:0]                   w_seg;
  logic                         w_tc;
  logic                         w_lzb;
  logic                         w_blank;

  assign w_code = r_dig[r_idx];
  assign w_tc   = r_cnt == TC;

`ifdef SEVEN_SEG_LZB_EN
  // A digit is blanked when it and every more significant digit are zero; ones always shows
  assign w_lzb = (r_idx == 2'd3 && r_dig[3] == 4'd0) ||
                 (r_idx == 2'd2 && r_dig[3] == 4'd0 && r_dig[2] == 4'd0) ||
                 (r_idx == 2'd1 && r_dig[3] == 4'd0 && r_dig[2] == 4'd0 && r_dig[1] == 4'd0);
`else
  assign w_lzb = 1'b0;
`endif

  // Signed compare keeps GUARD=0 a plain runtime-false test instead of a constant unsigned one
  assign w_blank = (int'(r_cnt) < GUARD) || w_lzb;

  seg7_decode u_decode (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // Capture shadows, advance slot counter and digit index, register display outputs from current state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_dig        <= '0;
      r_dp_en      <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_anode      <= ANODE_OFF;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      if (load) begin
        r_dig   <= {thousands, hundreds, tens, ones};
        r_dp_en <= dp_en;
      end
      r_cnt        <= w_tc ? '0 : r_cnt + 1'b1;
      r_idx        <= w_tc ? r_idx + 1'b1 : r_idx;
      r_frame_done <= w_tc && r_idx == 2'd3;
      r_anode      <= w_blank ? ANODE_OFF : ~(4'b0001 << r_idx);
      r_seg        <= w_blank ? SEG_BLANK : w_seg;
      r_dp         <= w_blank | ~r_dp_en[r_idx];
    end

  assign anode      = r_anode;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed bench for seven_seg_scanner with REFRESH_DIV=8, GUARD=2
module tb_seven_seg_scanner;
`ifdef SEVEN_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] th, hu, te, on, dpe;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  logic [3:0] m [4];
  logic [3:0] mdp;
  int e;
  int n_tests;
  int n_fail;
  int fd_count;

  seven_seg_scanner #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .thousands  (th),
    .hundreds   (hu),
    .tens       (te),
    .ones       (on),
    .dp_en      (dpe),
    .anode      (anode),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic lzb(input int i);
    return LZB && ((i == 3 && m[3] == 0) ||
                   (i == 2 && m[3] == 0 && m[2] == 0) ||
                   (i == 1 && m[3] == 0 && m[2] == 0 && m[1] == 0));
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // One clock: drive load, predict outputs from pre-edge slot position and shadows, check at negedge
  task automatic cycle(input logic ld);
    int c, i;
    logic blank, ed, ef;
    logic [3:0] ea;
    logic [6:0] es;
    load = ld;
    @(posedge clk);
    c = e % 8;
    i = (e / 8) % 4;
    blank = (c < 2) || lzb(i);
    ea = blank ? 4'hF : ~(4'b0001 << i);
    es = blank ? 7'h7F : dec(m[i]);
    ed = blank | ~mdp[i];
    ef = (c == 7) && (i == 3);
    if (ld) begin
      m[3] = th; m[2] = hu; m[1] = te; m[0] = on; mdp = dpe;
    end
    e++;
    @(negedge clk);
    load = 1'b0;
    chk("anode", 7'(anode), 7'(ea));
    chk("seg", seg, es);
    chk("dp", 7'(dp), 7'(ed));
    chk("frame_done", 7'(frame_done), 7'(ef));
    if (frame_done) fd_count++;
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d, input logic [3:0] p);
    th = a; hu = b; te = c; on = d; dpe = p;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; fd_count = 0; e = 0;
    m[0] = 0; m[1] = 0; m[2] = 0; m[3] = 0; mdp = 0;
    rst_n = 1'b0; load = 1'b0;
    set_digits(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("rst_anode", 7'(anode), 7'h0F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", 7'(dp), 7'h01);
    chk("rst_frame_done", 7'(frame_done), 7'h00);
    rst_n = 1'b1;
    // 1,2,3,4 with no decimal points: two full frames
    set_digits(4'h1, 4'h2, 4'h3, 4'h4, 4'h0);
    cycle(1'b1);
    repeat (63) cycle(1'b0);
    // F,b,C,0 with dp on digit 2
    set_digits(4'hF, 4'hB, 4'hC, 4'h0, 4'b0100);
    cycle(1'b1);
    repeat (63) cycle(1'b0);
    // 9999, then 0001 loaded mid ones-slot
    set_digits(4'h9, 4'h9, 4'h9, 4'h9, 4'h0);
    cycle(1'b1);
    repeat (31) cycle(1'b0);
    repeat (5) cycle(1'b0);
    chk("midload_before", seg, 7'h10);
    set_digits(4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
    cycle(1'b1);
    chk("midload_edge", seg, 7'h10);
    cycle(1'b0);
    chk("midload_after", seg, 7'h79);
    chk("midload_anode", 7'(anode), 7'h0E);
    repeat (25) cycle(1'b0);
    // 0,0,4,2: leading-zero slots blank only when blanking is enabled
    set_digits(4'h0, 4'h0, 4'h4, 4'h2, 4'h0);
    cycle(1'b1);
    repeat (31) cycle(1'b0);
    repeat (12) cycle(1'b0);
    chk("tens_anode", 7'(anode), 7'h0D);
    chk("tens_seg", seg, 7'h19);
    // asynchronous reset in the middle of the tens slot
    rst_n = 1'b0;
    #2;
    chk("async_anode", 7'(anode), 7'h0F);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", 7'(dp), 7'h01);
    chk("async_frame_done", 7'(frame_done), 7'h00);
    @(posedge clk);
    @(negedge clk);
    chk("held_anode", 7'(anode), 7'h0F);
    rst_n = 1'b1;
    e = 0; fd_count = 0;
    m[0] = 0; m[1] = 0; m[2] = 0; m[3] = 0; mdp = 0;
    repeat (3) cycle(1'b0);
    chk("restart_anode", 7'(anode), 7'h0E);
    chk("restart_seg", seg, 7'h40);
    repeat (28) cycle(1'b0);
    chk("no_early_frame", 7'(fd_count), 7'h00);
    cycle(1'b0);
    chk("first_frame", 7'(frame_done), 7'h01);
    repeat (32) cycle(1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
